// File: rtl/if_out_if.sv
// IF-to-ID handoff bundle: fetched pc, its sequential successor, instruction word and bubble flag.
// Purely combinational wiring; flow control lives in the stages on either side.
interface if_out_if;
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] instr;
    logic        bubble;

    modport master (output pc, output nextpc, output instr, output bubble);
    modport slave  (input  pc, input  nextpc, input  instr, input  bubble);
endinterface

// File: rtl/stage_if.sv
// Generic synchronous FIFO with flush (1-cycle push-to-head) and the IF fetch stage built on it.
// Fetch stage: response in cycle N shows at ID in N+1; requests stop once buffer plus in-flight reach depth.

module fifo_sync #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            cnt_d    = '0;
        end else begin
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_vld) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(push_vld) - CW'(pop_vld);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
endmodule

module stage_if #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXN_VECTOR = 32'h0000_0004,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    if_out_if.master          IF,
    input  logic              id_stall,
    input  logic              id_branch,
    input  logic [31:0]       id_branch_dest,
    input  logic              exn,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] nextpc;
        logic [31:0] instr;
    } if_view_t;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    if_view_t      last_q, last_d;

    fetch_ent_t    push_ent;
    fetch_ent_t    head_ent;
    if_view_t      live_view;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [CW:0]   occupancy;
    logic [CW-1:0] inflight;
    logic          fire;
    logic          keep;
    logic          pop;

    always_comb begin
        redirect    = exn | id_branch;
        redirect_pc = exn ? EXN_VECTOR : (id_branch_dest & ~32'h3);

        // Buffered plus in-flight never exceeds depth, so every grant owns a slot.
        occupancy = {1'b0, fifo_cnt} + {1'b0, out_cnt_q};
        imem_req  = rst_n && (occupancy < (CW+1)'(FIFO_DEPTH));
        imem_addr = fetch_pc_q;
        fire      = imem_req & imem_gnt;

        keep = imem_rvalid && (drop_cnt_q == '0) && !redirect;
        pop  = !id_stall && !fifo_empty && !redirect;

        inflight  = out_cnt_q + CW'(fire) - CW'(imem_rvalid);
        out_cnt_d = inflight;

        // On redirect everything still owed by memory is wrong-path, including this cycle's grant.
        if (redirect) begin
            drop_cnt_d = inflight;
        end else if (imem_rvalid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        if (redirect) begin
            resp_pc_d = redirect_pc;
        end else if (keep) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end else begin
            resp_pc_d = resp_pc_q;
        end

        push_ent.pc    = resp_pc_q;
        push_ent.instr = imem_rdata;

        live_view.pc     = head_ent.pc;
        live_view.nextpc = head_ent.pc + 32'd4;
        live_view.instr  = head_ent.instr;
        last_d           = fifo_empty ? last_q : live_view;
    end

    fifo_sync #(
        .WIDTH ($bits(fetch_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (keep),
        .push_dat (push_ent),
        .pop_vld  (pop),
        .flush    (redirect),
        .head_dat (head_ent),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            last_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            last_q     <= last_d;
        end
    end

    // While empty, ID sees the last presented entry (zero after reset).
    always_comb begin
        IF.bubble = fifo_empty;
        if (fifo_empty) begin
            IF.pc     = last_q.pc;
            IF.nextpc = last_q.nextpc;
            IF.instr  = last_q.instr;
        end else begin
            IF.pc     = live_view.pc;
            IF.nextpc = live_view.nextpc;
            IF.instr  = live_view.instr;
        end
    end
endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXN_VECTOR = 32'h0000_0004;
    localparam int          DEPTH      = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_stall = 1'b0;
    logic        id_branch = 1'b0;
    logic [31:0] id_branch_dest = '0;
    logic        exn = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    if_out_if ifo ();

    stage_if #(
        .RESET_PC   (RESET_PC),
        .EXN_VECTOR (EXN_VECTOR),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IF             (ifo),
        .id_stall       (id_stall),
        .id_branch      (id_branch),
        .id_branch_dest (id_branch_dest),
        .exn            (exn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_C0DE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: in-order responses, each due a random number of cycles after its grant.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t pend[$];
    int   cyc = 0;
    bit   mem_rand = 1'b0;

    task automatic step(input bit stall, input bit br, input bit ex,
                        input logic [31:0] dest, input bit rnd);
        @(negedge clk);
        if (rnd) begin
            stall = ($urandom_range(0, 3) == 0);
            br    = !stall && !ifo.bubble && ($urandom_range(0, 15) == 0);
            ex    = ($urandom_range(0, 39) == 0);
            dest  = $urandom;
        end
        id_stall       = stall;
        id_branch      = br;
        exn            = ex;
        id_branch_dest = dest;
        imem_gnt = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        if (imem_req && imem_gnt) begin
            chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            pend.push_back('{addr: imem_addr,
                             due: cyc + 1 + (mem_rand ? $urandom_range(0, 3) : 0)});
        end
        chk("outstanding_bound", 32'(pend.size() <= DEPTH), 32'd1);
        cyc++;
    endtask

    // Monitor: expected ID-visible stream is a pc that restarts at each redirect and advances by 4 per consume.
    logic [31:0] exp_q[$];
    bit          prev_redir = 1'b0;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_q.delete();
            exp_q.push_back(RESET_PC);
            prev_redir = 1'b0;
        end else begin
            if (prev_redir) begin
                chk("bubble_after_redirect", {31'b0, ifo.bubble}, 32'd1);
            end
            if (!ifo.bubble) begin
                chk("if_pc", ifo.pc, exp_q[0]);
                chk("if_nextpc", ifo.nextpc, exp_q[0] + 32'd4);
                chk("if_instr", ifo.instr, mem_word(exp_q[0]));
            end
            prev_redir = exn || id_branch;
            if (exn) begin
                exp_q.delete();
                exp_q.push_back(EXN_VECTOR);
            end else if (id_branch) begin
                exp_q.delete();
                exp_q.push_back(id_branch_dest & ~32'h3);
            end else if (!ifo.bubble && !id_stall) begin
                logic [31:0] p;
                p = exp_q.pop_front();
                exp_q.push_back(p + 32'd4);
            end
        end
    end

    logic [31:0] hold_pc;

    initial begin
        repeat (2) @(negedge clk);
        #3;
        chk("rst_bubble", {31'b0, ifo.bubble}, 32'd1);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_pc", ifo.pc, 32'd0);
        chk("rst_nextpc", ifo.nextpc, 32'd0);
        chk("rst_instr", ifo.instr, 32'd0);

        // Release with a 1-cycle memory: first instruction visible in the third cycle.
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        #3 chk("first_bubble_c1", {31'b0, ifo.bubble}, 32'd1);
        step(0, 0, 0, 0, 0);
        #3 chk("first_bubble_c2", {31'b0, ifo.bubble}, 32'd1);
        step(0, 0, 0, 0, 0);
        #3 chk("first_bubble_c3", {31'b0, ifo.bubble}, 32'd0);
        chk("first_pc_c3", ifo.pc, RESET_PC);
        repeat (6) step(0, 0, 0, 0, 0);

        // Stall: buffer fills, requests stop, head holds.
        step(1, 0, 0, 0, 0);
        #3 hold_pc = ifo.pc;
        repeat (4) step(1, 0, 0, 0, 0);
        #3 chk("stall_req", {31'b0, imem_req}, 32'd0);
        chk("stall_pc", ifo.pc, hold_pc);
        chk("stall_bubble", {31'b0, ifo.bubble}, 32'd0);
        repeat (4) step(0, 0, 0, 0, 0);

        // Branch while a request is outstanding and another is being granted.
        step(0, 1, 0, 32'h0000_0100, 0);
        repeat (6) step(0, 0, 0, 0, 0);

        // exn wins over a branch, even under stall.
        step(1, 1, 1, 32'h0000_0200, 0);
        step(0, 0, 0, 0, 0);
        #3 chk("exn_bubble", {31'b0, ifo.bubble}, 32'd1);
        repeat (8) step(0, 0, 0, 0, 0);

        mem_rand = 1'b1;
        repeat (3000) step(0, 0, 0, 0, 1);

        // Mid-stream reset with two requests outstanding.
        for (int i = 0; i < 200 && pend.size() != 2; i++) begin
            step(0, 0, 0, 0, 0);
        end
        chk("two_outstanding", 32'(pend.size()), 32'd2);
        #3 rst_n = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        pend.delete();
        #1;
        chk("arst_bubble", {31'b0, ifo.bubble}, 32'd1);
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_pc", ifo.pc, 32'd0);
        chk("arst_instr", ifo.instr, 32'd0);
        repeat (3) step(0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (600) step(0, 0, 0, 0, 1);

        @(negedge clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stage_if.md
Name: stage_if

Overview:
- Instruction-fetch stage, directly upstream of stage_id.
- Issues word fetches to the instruction memory port and buffers returned instructions in a small in-order FIFO.
- Presents the FIFO head to ID through if_out_if: pc, nextpc, instr and bubble.
- Handles redirects from ID branches and from exceptions, including discarding wrong-path responses that are still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- EXN_VECTOR, 32'h0000_0004, fetch address on exn.
- FIFO_DEPTH, 2, fetch-buffer entries (power of two, ≥2).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- IF  if_out_if.master  -  drives IF.pc[31:0], IF.nextpc[31:0], IF.instr[31:0], IF.bubble.
- id_stall  input  1  ID holds; IF output not consumed this cycle.
- id_branch  input  1  taken branch resolved in ID.
- id_branch_dest  input  32  branch target.
- exn  input  1  exception flush.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch word address, [1:0]=0.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; responses return in order, one per accepted request.
- imem_rdata  input  32  instruction word.

Behaviour:
- State:
  - fetch_pc: next address to request.
  - FIFO of {pc, instr}.
  - out_cnt: accepted requests not yet returned.
  - drop_cnt: returns still to be discarded.
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; out_cnt=0; drop_cnt=0.
  - imem_req=0; IF.bubble=1; IF.pc/nextpc/instr=0.
- Request issue:
  - imem_req=1 when rst_n=1 and fifo_count+out_cnt < FIFO_DEPTH. Every accepted request therefore has a guaranteed FIFO slot.
  - imem_addr=fetch_pc.
  - On req&&gnt, fetch_pc+=4 (wraps mod 2^32) and out_cnt increments.
  - req/addr may change before gnt; an ungranted request carries no commitment.
- Response handling, on rvalid:
  - out_cnt decrements.
  - If drop_cnt>0, drop_cnt decrements and the data is discarded.
  - Otherwise push {pc of that request, rdata}. The pc is tracked by a second pointer resp_pc that advances by 4 per kept response.
- Output:
  - Combinational from the FIFO head: IF.pc=head.pc, IF.nextpc=head.pc+4, IF.instr=head.instr.
  - IF.bubble=1 when the FIFO is empty.
  - When the FIFO is empty, pc/instr hold their last values (don't-care to ID).
- Consume: the head pops at the clock edge when !id_stall and the FIFO is non-empty.
- Latency: a response returned in cycle N is visible at IF (bubble=0) in cycle N+1. There is no bypass.
- Simultaneous push and pop: both occur; the count is unchanged.
- Redirect priority is exn over id_branch. Target T=EXN_VECTOR or {id_branch_dest[31:2],2'b0}. In the redirect cycle:
  - FIFO flushed (pop and push both suppressed); the current head is squashed.
  - fetch_pc<=T; resp_pc<=T.
  - drop_cnt<=out_cnt + (req&&gnt) − rvalid, i.e. every in-flight request, including one granted this cycle.
  - An rvalid arriving in the same cycle is discarded.
- exn while id_stall=1: the flush still occurs, since ID loads unconditionally on exn.
- id_branch while id_stall=1: cannot occur, because ID gates branch with !bubble and a stall holds the instruction. Treat it as a redirect anyway; no assertion is required.
- Back-to-back redirects: a second redirect recomputes drop_cnt from the live out_cnt, so earlier discards stay accounted.
- Counter widths: out_cnt and drop_cnt are $clog2(FIFO_DEPTH)+1 bits; drop_cnt ≤ out_cnt always.
- Reset mid-operation clears everything immediately. Responses to pre-reset requests must not arrive after reset; the memory is reset by the same rst_n.

Test Plan:
- Reset release, 1-cycle memory (gnt=1, rvalid the cycle after gnt), id_stall=0:
  - addrs 0x0,0x4,0x8… requested back-to-back.
  - IF shows pc=0x0 bubble=0 in cycle 3 after rst_n rise, then one instr per cycle.
- Hold id_stall=1 for 5 cycles with FIFO_DEPTH=2:
  - After 2 entries buffered, imem_req=0 and IF.pc is stable.
  - On release, pcs continue with no gap or duplicate.
- id_branch=1, dest=0x100, with 1 request outstanding and 1 granted that cycle:
  - drop_cnt=2; the next two rvalids are discarded.
  - The first non-bubble output is pc=0x100, nextpc=0x104.
- exn=1 with id_branch=1 and id_stall=1 in the same cycle:
  - Target is EXN_VECTOR=0x4; FIFO is empty next cycle; IF.bubble=1 until 0x4 returns.
- Memory with random gnt/rvalid delays (0–3 cycles) and random id_stall/branch:
  - Scoreboard: every non-bubble IF.instr equals mem[IF.pc].
  - pc sequence is sequential except at redirects.
  - out_cnt never exceeds FIFO_DEPTH.
- Assert rst_n=0 mid-stream with 2 outstanding:
  - Outputs reset asynchronously.
  - After release, fetch restarts at RESET_PC and no stale data appears.
